// File: rtl/branch_resolve_unit_pkg.sv
// Purpose: shared word width, condition codes and code classification for branch_resolve_unit.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package branch_resolve_unit_pkg;

    localparam int BRU_WORD_LEN = 32;

    // Condition codes issued by the control unit; 0110-1001 are the SLT family, not branches.
    typedef enum logic [3:0] {
        COND_NOTHING = 4'b0000,
        COND_BNE     = 4'b0001,
        COND_JUMP    = 4'b0010,
        COND_BEQ     = 4'b0011,
        COND_JAL     = 4'b0100,
        COND_JR      = 4'b0101,
        COND_SLT     = 4'b0110,
        COND_SLTU    = 4'b0111,
        COND_SLTI    = 4'b1000,
        COND_SLTIU   = 4'b1001,
        COND_BLTZ    = 4'b1010,
        COND_BGEZ    = 4'b1011,
        COND_BLEZ    = 4'b1100,
        COND_BGTZ    = 4'b1101,
        COND_RSVD_E  = 4'b1110,
        COND_RSVD_F  = 4'b1111
    } cond_e;

    // Data-dependent branches: these are predicted and train the PHT.
    function automatic logic is_cond_branch(input logic [3:0] code);
        return (code == COND_BNE)  || (code == COND_BEQ)  ||
               (code == COND_BLTZ) || (code == COND_BGEZ) ||
               (code == COND_BLEZ) || (code == COND_BGTZ);
    endfunction

    // Unconditional transfers: always taken and resolved in ID, never mispredicted.
    function automatic logic is_uncond_jump(input logic [3:0] code);
        return (code == COND_JUMP) || (code == COND_JAL) || (code == COND_JR);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Purpose: ID-side instruction bundle in, registered EX-side branch outcome out.
// Latency: n/a (wiring only); the resolved outcome appears one cycle after the ID fields.
// Backpressure: none on the bus itself; the stall/flush scalars on the unit govern it.
interface branch_resolve_unit_if
    import branch_resolve_unit_pkg::*;
#(
    parameter int WORD_LEN = BRU_WORD_LEN
);
    logic                valid_in;
    logic [3:0]          cond_code;
    logic [WORD_LEN-1:0] reg1;
    logic [WORD_LEN-1:0] reg2;
    logic [WORD_LEN-1:0] pc_in;
    logic                pred_taken_in;
    logic                br_valid;
    logic                br_taken;
    logic                mispredict;

    modport master (
        output valid_in, cond_code, reg1, reg2, pc_in, pred_taken_in,
        input  br_valid, br_taken, mispredict
    );

    modport slave (
        input  valid_in, cond_code, reg1, reg2, pc_in, pred_taken_in,
        output br_valid, br_taken, mispredict
    );
endinterface

// File: rtl/branch_resolve_unit_pht.sv
// Purpose: pattern history table of saturating counters, combinational read of counter MSB.
// Latency: read is combinational; a training write lands at the next rising edge (no bypass).
// Backpressure: none; the caller gates wr_en with stall/flush.
module branch_pht
    import branch_resolve_unit_pkg::*;
#(
    parameter int PHT_DEPTH = 16,
    parameter int CTR_BITS  = 2,
    localparam int IDX_W    = $clog2(PHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_msb,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    // Weakly-not-taken start point; collapses to 0 for single-bit counters.
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0] ctr_q [PHT_DEPTH];
    logic [CTR_BITS-1:0] ctr_d;

    // The prediction is simply the top bit of the addressed counter.
    assign rd_msb = ctr_q[rd_idx][CTR_BITS-1];

    // Next value of the trained counter, clamped at both ends instead of wrapping.
    always_comb begin
        ctr_d = ctr_q[wr_idx];
        if (wr_taken) begin
            if (ctr_q[wr_idx] != CTR_MAX) ctr_d = ctr_q[wr_idx] + 1'b1;
        end else begin
            if (ctr_q[wr_idx] != '0) ctr_d = ctr_q[wr_idx] - 1'b1;
        end
    end

    // Whole-table reinitialisation on reset, otherwise single-entry training.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) ctr_q[i] <= CTR_INIT;
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Purpose: resolve ID branch/jump condition into EX registers, flag mispredicts, own the PHT (stats under BRANCH_STATS_EN).
// Latency: 1 cycle from ID inputs to br_valid/br_taken/mispredict; fetch_pred_taken is combinational.
// Backpressure: stall holds every register and the PHT; flush (wins over stall) zeroes the outputs.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int WORD_LEN  = BRU_WORD_LEN,
    parameter int PHT_DEPTH = 16,
    parameter int CTR_BITS  = 2
) (
    input  logic                clk,
    input  logic                rst,
    branch_resolve_unit_if.slave bus,
    input  logic                stall,
    input  logic                flush,
    input  logic [WORD_LEN-1:0] fetch_pc,
    output logic                fetch_pred_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);
    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic is_cond, is_br, cond_taken, reg1_neg, reg1_zero, advance, pht_wr_en;
    logic br_valid_d, br_taken_d, mispredict_d;
    logic br_valid_q, br_taken_q, mispredict_q;
    logic unused_pc_bits;

    assign is_cond   = is_cond_branch(bus.cond_code);
    assign is_br     = is_cond | is_uncond_jump(bus.cond_code);
    assign reg1_neg  = bus.reg1[WORD_LEN-1];
    assign reg1_zero = (bus.reg1 == '0);
    assign advance   = !flush && !stall;

    // Evaluate the branch condition; non-branch codes resolve as not taken.
    always_comb begin
        cond_taken = 1'b0;
        case (bus.cond_code)
            COND_BNE:                    cond_taken = (bus.reg1 != bus.reg2);
            COND_BEQ:                    cond_taken = (bus.reg1 == bus.reg2);
            COND_JUMP, COND_JAL, COND_JR: cond_taken = 1'b1;
            COND_BLTZ:                   cond_taken = reg1_neg;
            COND_BGEZ:                   cond_taken = !reg1_neg;
            COND_BLEZ:                   cond_taken = reg1_neg || reg1_zero;
            COND_BGTZ:                   cond_taken = !reg1_neg && !reg1_zero;
            default:                     cond_taken = 1'b0;
        endcase
    end

    assign br_valid_d   = bus.valid_in && is_br;
    assign br_taken_d   = bus.valid_in && cond_taken;
    // Jumps are resolved in ID, so only conditional branches can mispredict.
    assign mispredict_d = br_valid_d && is_cond && (br_taken_d != bus.pred_taken_in);
    assign pht_wr_en    = advance && bus.valid_in && is_cond;

    // EX-stage outcome registers: reset, then flush, then stall-hold, then capture.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            br_valid_q   <= 1'b0;
            br_taken_q   <= 1'b0;
            mispredict_q <= 1'b0;
        end else if (!stall) begin
            br_valid_q   <= br_valid_d;
            br_taken_q   <= br_taken_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign bus.br_valid   = br_valid_q;
    assign bus.br_taken   = br_taken_q;
    assign bus.mispredict = mispredict_q;

    branch_pht #(
        .PHT_DEPTH (PHT_DEPTH),
        .CTR_BITS  (CTR_BITS)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (fetch_pc[IDX_W+1:2]),
        .rd_msb   (fetch_pred_taken),
        .wr_en    (pht_wr_en),
        .wr_idx   (bus.pc_in[IDX_W+1:2]),
        .wr_taken (cond_taken)
    );

    // PC bits outside the word-aligned index never address the table.
    assign unused_pc_bits = ^{bus.pc_in[WORD_LEN-1:IDX_W+2], bus.pc_in[1:0],
                              fetch_pc[WORD_LEN-1:IDX_W+2], fetch_pc[1:0]};

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_mispredicts_q;

    // Saturating event counters that follow the same advance rule as the outcome registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else if (advance) begin
            if (br_valid_d && is_cond && stat_branches_q != '1)
                stat_branches_q <= stat_branches_q + 32'd1;
            if (mispredict_d && stat_mispredicts_q != '1)
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Purpose: self-checking bench for branch_resolve_unit (directed scenarios plus randomized run vs. a reference model).
// Latency: outputs checked one cycle after the driving edge; fetch prediction checked combinationally.
// Backpressure: stall/flush exercised directly and randomly.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: counter per PHT entry, expected {br_valid, br_taken, mispredict}.
    int          pht_m [16];
    logic [2:0]  exp_out;
    longint      exp_sb, exp_sm;

    branch_resolve_unit_if #(.WORD_LEN(32)) bus ();

    branch_resolve_unit dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .stall            (stall),
        .flush            (flush),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] outs();
        return {bus.br_valid, bus.br_taken, bus.mispredict};
    endfunction

    // Classify a code and decide its direction straight from the ISA rules.
    task automatic classify(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            output bit taken, output bit cond, output bit uncond);
        int s;
        s = $signed(a);
        taken = 0; cond = 0; uncond = 0;
        case (c)
            4'h1: begin cond = 1; taken = (a != b); end
            4'h3: begin cond = 1; taken = (a == b); end
            4'h2, 4'h4, 4'h5: begin uncond = 1; taken = 1; end
            4'hA: begin cond = 1; taken = (s < 0);  end
            4'hB: begin cond = 1; taken = (s >= 0); end
            4'hC: begin cond = 1; taken = (s <= 0); end
            4'hD: begin cond = 1; taken = (s > 0);  end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        bit taken, cond, uncond, v, t, m;
        int idx;
        classify(bus.cond_code, bus.reg1, bus.reg2, taken, cond, uncond);
        if (rst) begin
            exp_out = 3'b000;
            for (int i = 0; i < 16; i++) pht_m[i] = 1;
            exp_sb = 0; exp_sm = 0;
        end else if (flush) begin
            exp_out = 3'b000;
        end else if (!stall) begin
            v = bus.valid_in && (cond || uncond);
            t = bus.valid_in && taken;
            m = v && cond && (t != bus.pred_taken_in);
            exp_out = {v, t, m};
            if (bus.valid_in && cond) begin
                idx = (bus.pc_in / 4) % 16;
                if (taken) pht_m[idx] = (pht_m[idx] < 3) ? pht_m[idx] + 1 : 3;
                else       pht_m[idx] = (pht_m[idx] > 0) ? pht_m[idx] - 1 : 0;
            end
            if (v && cond && exp_sb < 64'hFFFF_FFFF) exp_sb++;
            if (m && exp_sm < 64'hFFFF_FFFF) exp_sm++;
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic p);
        bus.valid_in = v; bus.cond_code = c; bus.reg1 = a; bus.reg2 = b;
        bus.pc_in = pc; bus.pred_taken_in = p;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; flush = 0; fetch_pc = 32'h40;
        drive(0, 4'h0, 0, 0, 0, 0);
        step();
        tests_run++;
        if (outs() !== 3'b000) begin tests_failed++; $display("FAIL reset_outs: got %b expected 000", outs()); end
        tests_run++;
        if (fetch_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_pred: got %b expected 0", fetch_pred_taken); end
        rst = 0;
    endtask

    task automatic test_beq_mispredict();
        drive(1, 4'h3, 32'h5, 32'h5, 32'h40, 0);
        fetch_pc = 32'h40;
        step();
        tests_run++;
        if (outs() !== 3'b111) begin tests_failed++; $display("FAIL beq_outs: got %b expected 111", outs()); end
        drive(0, 4'h0, 0, 0, 0, 0);
        #1;
        tests_run++;
        if (fetch_pred_taken !== 1'b1) begin tests_failed++; $display("FAIL beq_pred: got %b expected 1", fetch_pred_taken); end
    endtask

    task automatic test_saturation();
        fetch_pc = 32'h44;
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'h1, 32'h1, 32'h2, 32'h44, 1);
            step();
            tests_run++;
            if (outs() !== 3'b110) begin tests_failed++; $display("FAIL sat_taken%0d: got %b expected 110", i, outs()); end
        end
        // Counter now pinned at 3: one not-taken leaves 2 (still predicts taken), a second gives 1.
        drive(1, 4'h1, 32'h7, 32'h7, 32'h44, 1);
        step();
        tests_run++;
        if (outs() !== 3'b101) begin tests_failed++; $display("FAIL sat_nt_outs: got %b expected 101", outs()); end
        tests_run++;
        if (fetch_pred_taken !== 1'b1) begin tests_failed++; $display("FAIL sat_pred_after1: got %b expected 1", fetch_pred_taken); end
        step();
        tests_run++;
        if (fetch_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL sat_pred_after2: got %b expected 0", fetch_pred_taken); end
    endtask

    task automatic test_signed();
        logic [3:0]  codes [6] = '{4'hA, 4'hD, 4'hC, 4'hB, 4'hD, 4'hB};
        logic [31:0] vals  [6] = '{32'h8000_0000, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [2:0]  exps  [6] = '{3'b111, 3'b100, 3'b111, 3'b111, 3'b100, 3'b100};
        for (int i = 0; i < 6; i++) begin
            drive(1, codes[i], vals[i], 32'h0, 32'h50, 0);
            step();
            tests_run++;
            if (outs() !== exps[i]) begin tests_failed++; $display("FAIL signed%0d: got %b expected %b", i, outs(), exps[i]); end
        end
    endtask

    task automatic test_stall_flush();
        fetch_pc = 32'h60;
        drive(1, 4'h3, 32'h9, 32'h9, 32'h60, 1);
        step();
        tests_run++;
        if (outs() !== 3'b110) begin tests_failed++; $display("FAIL sf_setup: got %b expected 110", outs()); end
        stall = 1;
        drive(1, 4'h3, 32'h1, 32'h2, 32'h60, 1);
        step();
        tests_run++;
        if (outs() !== 3'b110) begin tests_failed++; $display("FAIL stall_hold: got %b expected 110", outs()); end
        tests_run++;
        if (fetch_pred_taken !== 1'b1) begin tests_failed++; $display("FAIL stall_pht: got %b expected 1", fetch_pred_taken); end
        flush = 1;
        step();
        tests_run++;
        if (outs() !== 3'b000) begin tests_failed++; $display("FAIL flush_outs: got %b expected 000", outs()); end
        tests_run++;
        if (fetch_pred_taken !== 1'b1) begin tests_failed++; $display("FAIL flush_pht: got %b expected 1", fetch_pred_taken); end
        stall = 0; flush = 0;
    endtask

    task automatic test_jump_nonbranch();
        logic [3:0] codes [7] = '{4'h6, 4'h9, 4'hE, 4'h5, 4'h2, 4'h4, 4'h0};
        logic [2:0] exps  [7] = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b110, 3'b110, 3'b000};
        fetch_pc = 32'h70;
        for (int i = 0; i < 7; i++) begin
            drive(1, codes[i], 32'h3, 32'h3, 32'h70, 0);
            step();
            tests_run++;
            if (outs() !== exps[i]) begin tests_failed++; $display("FAIL jump%0d: got %b expected %b", i, outs(), exps[i]); end
        end
        tests_run++;
        if (fetch_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL jump_pht: got %b expected 0", fetch_pred_taken); end
        drive(0, 4'h3, 32'h3, 32'h3, 32'h70, 0);
        step();
        tests_run++;
        if (outs() !== 3'b000) begin tests_failed++; $display("FAIL invalid_beq: got %b expected 000", outs()); end
    endtask

    task automatic test_random();
        logic [31:0] a, pool [6];
        bit exp_pred;
        int errs = 0;
        rst = 1; step(); rst = 0;
        for (int n = 0; n < 400; n++) begin
            pool = '{32'h0, $urandom, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'hFFFF_FFFF};
            a = pool[$urandom_range(0, 5)];
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a,
                  ($urandom_range(0, 1) == 1) ? a : $urandom,
                  32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3) + 32'h100), $urandom_range(0, 1) == 1);
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 59) == 0);
            fetch_pc = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3) + 32'h200);
            #1;
            exp_pred = pht_m[(fetch_pc / 4) % 16] >= 2;
            tests_run++;
            if (fetch_pred_taken !== exp_pred) begin
                tests_failed++; errs++;
                if (errs < 10) $display("FAIL rand_pred%0d: got %b expected %b", n, fetch_pred_taken, exp_pred);
            end
            step();
            tests_run++;
            if (outs() !== exp_out) begin
                tests_failed++; errs++;
                if (errs < 10) $display("FAIL rand_outs%0d: got %b expected %b", n, outs(), exp_out);
            end
        end
        rst = 0; stall = 0; flush = 0;
`ifdef BRANCH_STATS_EN
        tests_run++;
        if (stat_branches !== 32'(exp_sb)) begin tests_failed++; $display("FAIL stat_br: got %0d expected %0d", stat_branches, exp_sb); end
        tests_run++;
        if (stat_mispredicts !== 32'(exp_sm)) begin tests_failed++; $display("FAIL stat_mis: got %0d expected %0d", stat_mispredicts, exp_sm); end
`endif
    endtask

    initial begin
        test_reset();
        test_beq_mispredict();
        test_saturation();
        test_signed();
        test_stall_flush();
        test_jump_nonbranch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
